sdram_frame_sched: RTL and testbench

- Schedules SDRAM burst traffic for the camera frame buffer in the sclk domain.
- Arbitrates between two requesters:
  - draining the camera write FIFO, which is filled by the FIFO write-enable pulses;
  - refilling the display read FIFO.
- Issues one burst command at a time to the SDRAM controller.
- Manages ping-pong frame banks so the display always reads the last complete frame.

---
 rtl/sdram_frame_sched.sv | 181 ++++++++++++++++++
 tb/tb_sdram_frame_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_sched.sv
// Ping-pong frame-buffer burst scheduler for the SDRAM controller.
// Arbitrates camera write drains against display read refills.
module sdram_frame_sched #(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int OFS_W       = 19,
  parameter int FIFO_DEPTH  = 512,
  parameter int RD_LOW      = 64
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             init_done,
  input  logic             frame_start,
  input  logic             rd_enable,
  input  logic [9:0]       wfifo_used,
  input  logic [9:0]       rfifo_used,
  output logic             cmd_req,
  output logic             cmd_wr,
  output logic [OFS_W:0]   cmd_addr,
  input  logic             cmd_ack,
  input  logic             burst_done,
  output logic             wr_bank,
  output logic             rd_bank,
  output logic             overflow
);

  localparam logic [9:0] WR_MIN  = 10'(BURST_LEN);
  localparam logic [9:0] RD_MAX  = 10'(FIFO_DEPTH - BURST_LEN);
  localparam logic [9:0] RD_URG  = 10'(RD_LOW);
  localparam logic [9:0] OVF_LVL = 10'(FIFO_DEPTH - 1);
  localparam logic [OFS_W-1:0] BL_O = OFS_W'(BURST_LEN);
  localparam logic [OFS_W-1:0] FW_O = OFS_W'(FRAME_WORDS);

  typedef enum logic [2:0] {
    IDLE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [OFS_W-1:0] wr_ofs_q, wr_ofs_d;
  logic [OFS_W-1:0] rd_ofs_q, rd_ofs_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             last_wr_q, last_wr_d;
  logic             pend_q, pend_d;
  logic             rd_clr_q, rd_clr_d;
  logic             ovf_q, ovf_d;
  logic             req_q, req_d;
  logic             cwr_q, cwr_d;
  logic [OFS_W:0]   addr_q, addr_d;

  logic             wr_need, rd_need, rd_urgent;
  logic             go_wr, go_rd;
  logic [OFS_W-1:0] wr_sum, rd_sum;

  assign wr_need   = wfifo_used >= WR_MIN;
  assign rd_need   = rd_enable && (rfifo_used <= RD_MAX);
  assign rd_urgent = rd_need && (rfifo_used < RD_URG);
  assign wr_sum    = wr_ofs_q + BL_O;
  assign rd_sum    = rd_ofs_q + BL_O;

  always_comb begin
    go_wr = 1'b0;
    go_rd = 1'b0;
    if (init_done) begin
      if (rd_urgent)            go_rd = 1'b1;
      else if (wr_need && rd_need) begin
        go_wr = !last_wr_q;
        go_rd = last_wr_q;
      end
      else if (wr_need)         go_wr = 1'b1;
      else if (rd_need)         go_rd = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ofs_d  = wr_ofs_q;
    rd_ofs_d  = rd_ofs_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    last_wr_d = last_wr_q;
    pend_d    = pend_q;
    rd_clr_d  = rd_clr_q;
    req_d     = req_q;
    cwr_d     = cwr_q;
    addr_d    = addr_q;
    ovf_d     = (wfifo_used >= OVF_LVL) ? 1'b1 :
                frame_start ? 1'b0 : ovf_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) wr_ofs_d = '0;
        if (!rd_enable)  rd_ofs_d = '0;
        if (go_wr) begin
          state_d   = WR_CMD;
          last_wr_d = 1'b1;
          req_d     = 1'b1;
          cwr_d     = 1'b1;
          addr_d    = {wr_bank_q, wr_ofs_d};
        end else if (go_rd) begin
          state_d   = RD_CMD;
          last_wr_d = 1'b0;
          req_d     = 1'b1;
          cwr_d     = 1'b0;
          addr_d    = {rd_bank_q, rd_ofs_d};
        end
      end
      WR_CMD, WR_WAIT: begin
        if (frame_start) pend_d   = 1'b1;
        if (!rd_enable)  rd_ofs_d = '0;
        if (state_q == WR_CMD) begin
          if (cmd_ack) begin
            state_d = WR_WAIT;
            req_d   = 1'b0;
          end
        end else if (burst_done) begin
          // resync and frame wrap both land the pointer at 0
          wr_ofs_d = (wr_sum == FW_O || pend_q || frame_start)
                     ? '0 : wr_sum;
          if (wr_sum == FW_O) wr_bank_d = !wr_bank_q;
          pend_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RD_CMD, RD_WAIT: begin
        if (frame_start) wr_ofs_d = '0;
        if (!rd_enable)  rd_clr_d = 1'b1;
        if (state_q == RD_CMD) begin
          if (cmd_ack) begin
            state_d = RD_WAIT;
            req_d   = 1'b0;
          end
        end else if (burst_done) begin
          rd_ofs_d = (rd_sum == FW_O || rd_clr_q || !rd_enable)
                     ? '0 : rd_sum;
          if (rd_sum == FW_O) rd_bank_d = !wr_bank_q;
          rd_clr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ofs_q  <= '0;
      rd_ofs_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
      last_wr_q <= 1'b0;
      pend_q    <= 1'b0;
      rd_clr_q  <= 1'b0;
      ovf_q     <= 1'b0;
      req_q     <= 1'b0;
      cwr_q     <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ofs_q  <= wr_ofs_d;
      rd_ofs_q  <= rd_ofs_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      last_wr_q <= last_wr_d;
      pend_q    <= pend_d;
      rd_clr_q  <= rd_clr_d;
      ovf_q     <= ovf_d;
      req_q     <= req_d;
      cwr_q     <= cwr_d;
      addr_q    <= addr_d;
    end
  end

  assign cmd_req  = req_q;
  assign cmd_wr   = cwr_q;
  assign cmd_addr = addr_q;
  assign wr_bank  = wr_bank_q;
  assign rd_bank  = rd_bank_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sdram_frame_sched.sv
// Scoreboard bench for sdram_frame_sched: the stimulus queues expected
// burst commands, a monitor checks each command as it is presented.
module tb_sdram_frame_sched;

  localparam int OFS_W = 19;
  localparam int FW    = 1024;

  logic           sclk = 1'b0;
  logic           rst_n = 1'b0;
  logic           init_done = 1'b1;
  logic           frame_start = 1'b0;
  logic           rd_enable = 1'b1;
  logic [9:0]     wfifo_used = '0;
  logic [9:0]     rfifo_used = 10'd500;
  logic           cmd_req;
  logic           cmd_wr;
  logic [OFS_W:0] cmd_addr;
  logic           cmd_ack = 1'b0;
  logic           burst_done = 1'b0;
  logic           wr_bank;
  logic           rd_bank;
  logic           overflow;

  int n_chk  = 0;
  int n_pass = 0;
  logic [OFS_W+1:0] exp_q[$];
  logic [OFS_W+1:0] cur;
  bit               in_cmd = 1'b0;

  sdram_frame_sched #(.FRAME_WORDS(FW), .OFS_W(OFS_W)) dut (
    .sclk(sclk), .rst_n(rst_n), .init_done(init_done),
    .frame_start(frame_start), .rd_enable(rd_enable),
    .wfifo_used(wfifo_used), .rfifo_used(rfifo_used),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_ack(cmd_ack), .burst_done(burst_done),
    .wr_bank(wr_bank), .rd_bank(rd_bank), .overflow(overflow)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(input bit wr, input bit bank, input int ofs);
    logic [OFS_W-1:0] o;
    o = OFS_W'(ofs);
    exp_q.push_back({wr, bank, o});
  endtask

  // monitor: checks each command on its rising cmd_req
  always @(posedge sclk) begin
    #1;
    if (cmd_ack) begin
      chk("req_drop_after_ack", {31'd0, cmd_req}, 32'd0);
      in_cmd = 1'b0;
    end else if (cmd_req && !in_cmd) begin
      in_cmd = 1'b1;
      cur = {cmd_wr, cmd_addr};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_cmd got=%0h want=none", cur);
      end else begin
        logic [OFS_W+1:0] e;
        e = exp_q.pop_front();
        if (cur !== e)
          $display("FAIL cmd got=%0h want=%0h", cur, e);
        else
          n_pass++;
      end
    end else if (cmd_req) begin
      chk("cmd_hold", 32'({cmd_wr, cmd_addr}), 32'(cur));
    end
  end

  // plays the SDRAM controller for one burst
  task automatic serve(input int dly, input bit fs, input bit rst);
    int t;
    t = 0;
    while (!cmd_req && t < 50) begin
      @(negedge sclk);
      t++;
    end
    if (!cmd_req) begin
      n_chk++;
      $display("FAIL serve_timeout got cmd_req=0 want=1");
      return;
    end
    repeat (dly) @(negedge sclk);
    cmd_ack = 1'b1;
    @(negedge sclk);
    cmd_ack = 1'b0;
    if (rst) begin
      rst_n = 1'b0;
      @(negedge sclk);
      chk("rst_cmd_req", {31'd0, cmd_req}, 32'd0);
      chk("rst_cmd_wr", {31'd0, cmd_wr}, 32'd0);
      chk("rst_cmd_addr", 32'(cmd_addr), 32'd0);
      chk("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
      chk("rst_rd_bank", {31'd0, rd_bank}, 32'd1);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      rst_n = 1'b1;
      return;
    end
    if (fs) begin
      frame_start = 1'b1;
      @(negedge sclk);
      frame_start = 1'b0;
    end
    @(negedge sclk);
    burst_done = 1'b1;
    @(negedge sclk);
    burst_done = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sclk);
    chk("reset_cmd_req", {31'd0, cmd_req}, 32'd0);
    chk("reset_rd_bank", {31'd0, rd_bank}, 32'd1);
    chk("reset_wr_bank", {31'd0, wr_bank}, 32'd0);
    chk("reset_overflow", {31'd0, overflow}, 32'd0);
    rfifo_used = 10'd510;
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    chk("idle_no_req", {31'd0, cmd_req}, 32'd0);

    // non-urgent contention alternates, write first
    wfifo_used = 10'd8;
    rfifo_used = 10'd300;
    for (int k = 0; k < 3; k++) begin
      push(1, 0, 8 * k);
      serve(0, 0, 0);
      push(0, 1, 8 * k);
      serve(0, 0, 0);
    end

    // urgent read beats a deep write FIFO
    rfifo_used = 10'd10;
    wfifo_used = 10'd200;
    for (int k = 0; k < 3; k++) begin
      push(0, 1, 24 + 8 * k);
      serve(0, 0, 0);
    end
    rfifo_used = 10'd300;
    push(1, 0, 24);
    serve(0, 0, 0);
    wfifo_used = 10'd0;
    rfifo_used = 10'd510;
    init_done = 1'b0;

    // overflow sticky, set wins over frame_start
    @(negedge sclk);
    wfifo_used = 10'd511;
    @(negedge sclk);
    wfifo_used = 10'd0;
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    @(negedge sclk);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    frame_start = 1'b1;
    wfifo_used = 10'd511;
    @(negedge sclk);
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    wfifo_used = 10'd0;
    @(negedge sclk);
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    frame_start = 1'b0;
    init_done = 1'b1;

    // full write frame from offset 0 (idle frame_start reset it)
    wfifo_used = 10'd8;
    for (int k = 0; k < FW / 8; k++) begin
      push(1, 0, 8 * k);
      serve(0, 0, 0);
    end
    wfifo_used = 10'd0;
    chk("wrap_wr_bank", {31'd0, wr_bank}, 32'd1);

    // read frame completes from offset 48
    rfifo_used = 10'd300;
    for (int k = 0; k < (FW - 48) / 8; k++) begin
      push(0, 1, 48 + 8 * k);
      serve(0, 0, 0);
    end
    chk("wrap_rd_bank", {31'd0, rd_bank}, 32'd0);
    push(0, 0, 0);
    serve(0, 0, 0);
    rd_enable = 1'b0;
    repeat (2) @(negedge sclk);
    rd_enable = 1'b1;
    push(0, 0, 0);
    serve(0, 0, 0);
    rfifo_used = 10'd510;

    // frame_start during a write burst at offset 1000
    wfifo_used = 10'd8;
    for (int k = 0; k < 125; k++) begin
      push(1, 1, 8 * k);
      serve(0, 0, 0);
    end
    push(1, 1, 1000);
    serve(0, 1, 0);
    chk("fs_wr_bank", {31'd0, wr_bank}, 32'd1);
    push(1, 1, 0);
    serve(5, 0, 0);
    push(1, 1, 8);
    serve(0, 0, 1);
    push(1, 0, 0);
    serve(0, 0, 0);
    wfifo_used = 10'd0;

    repeat (5) @(negedge sclk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
